// File: rtl/seq_trigger_pkg.sv
// Shared types and helpers for the sequential trigger detector.
// The optional stage timeout is enabled by defining SEQ_TRIGGER_TIMEOUT_EN.
package seq_trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } trig_state_t;

   // Limits a programmed final-stage index to the stages that actually exist.
   function automatic int clamp_last_stage(input int last_stage, input int stages);
      if (last_stage > stages - 1)
         return stages - 1;
      return last_stage;
   endfunction

endpackage

// File: rtl/seq_trigger_detector_cmp.sv
// One trigger stage: masked pattern compare and rising-edge qualification.
// The previous match is registered every cycle so edges are seen in any FSM state.
import seq_trigger_pkg::*;

module trig_stage_cmp #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] pattern,
   input  logic [WIDTH-1:0] mask,
   output logic             match,
   output logic             rise
);

   logic prev_match_reg;

   // Bits with a clear mask are ignored, so an all-zero mask always matches.
   assign match = ((in_data & mask) == (pattern & mask));
   assign rise  = match & ~prev_match_reg;

   always_ff @(posedge clk) begin
      if (rst)
         prev_match_reg <= 1'b0;
      else
         prev_match_reg <= match;
   end

endmodule

// File: rtl/seq_trigger_detector.sv
// Multi-stage ordered trigger: FSM, optional stage timeout, capture and trigger counter.
// Define SEQ_TRIGGER_TIMEOUT_EN to build the per-stage timeout timer.
import seq_trigger_pkg::*;

module seq_trigger_detector #(
   parameter int  WIDTH  = 4,
   parameter int  STAGES = 4,
   parameter int  TW     = 8,
   parameter int  CW     = 8,
   localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [STAGES*WIDTH-1:0]  cfg_pattern,
   input  logic [STAGES*WIDTH-1:0]  cfg_mask,
   input  logic [SW-1:0]            cfg_last_stage,
   input  logic [TW-1:0]            cfg_timeout,
   output logic [1:0]               state,
   output logic [SW-1:0]            stage_idx,
   output logic                     trig_pulse,
   output logic                     triggered,
   output logic                     timeout_pulse,
   output logic [WIDTH-1:0]         cap_data,
   output logic [CW-1:0]            trig_count
);

   trig_state_t       state_reg;
   logic [STAGES-1:0] match;
   logic [STAGES-1:0] rise;
   logic [SW-1:0]     eff_last;
   logic              cur_rise;
   logic              timeout_hit;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         trig_stage_cmp #(
            .WIDTH (WIDTH)
         ) u_cmp (
            .clk     (clk),
            .rst     (rst),
            .in_data (in_data),
            .pattern (cfg_pattern[gi*WIDTH +: WIDTH]),
            .mask    (cfg_mask[gi*WIDTH +: WIDTH]),
            .match   (match[gi]),
            .rise    (rise[gi])
         );
      end
   endgenerate

   assign eff_last = SW'(clamp_last_stage(int'(cfg_last_stage), STAGES));
   assign cur_rise = rise[stage_idx];
   assign state    = state_reg;

`ifdef SEQ_TRIGGER_TIMEOUT_EN
   logic [TW-1:0] timer_reg;

   // An edge in the same cycle always wins over the timeout.
   assign timeout_hit = (state_reg == ST_WAIT) && (stage_idx != '0) &&
                        (cfg_timeout != '0) && !cur_rise &&
                        (timer_reg == cfg_timeout - TW'(1));

   always_ff @(posedge clk) begin
      if (rst)
         timer_reg <= '0;
      else if (abort || arm || state_reg != ST_WAIT || cur_rise || timeout_hit ||
               stage_idx == '0 || cfg_timeout == '0)
         timer_reg <= '0;
      else
         timer_reg <= timer_reg + TW'(1);
   end
`else
   logic unused_cfg_timeout;

   assign unused_cfg_timeout = ^cfg_timeout;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         stage_idx     <= '0;
         trig_pulse    <= 1'b0;
         triggered     <= 1'b0;
         timeout_pulse <= 1'b0;
         cap_data      <= '0;
         trig_count    <= '0;
      end else begin
         trig_pulse    <= 1'b0;
         timeout_pulse <= 1'b0;
         if (abort) begin
            state_reg <= ST_IDLE;
            stage_idx <= '0;
            triggered <= 1'b0;
         end else if (arm) begin
            state_reg <= ST_WAIT;
            stage_idx <= '0;
            triggered <= 1'b0;
         end else begin
            case (state_reg)
               ST_WAIT: begin
                  if (cur_rise) begin
                     if (stage_idx == eff_last) begin
                        state_reg  <= ST_DONE;
                        triggered  <= 1'b1;
                        trig_pulse <= 1'b1;
                        cap_data   <= in_data;
                        if (trig_count != '1)
                           trig_count <= trig_count + CW'(1);
                     end else begin
                        // Only the current stage is examined, so at most one advance per cycle.
                        stage_idx <= stage_idx + SW'(1);
                     end
                  end else if (timeout_hit) begin
                     stage_idx     <= '0;
                     timeout_pulse <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_reg <= ST_DONE;
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_trigger_detector.sv
// Directed bench for seq_trigger_detector with a cycle-level reference model.
// Timeout scenarios are exercised only when SEQ_TRIGGER_TIMEOUT_EN is defined.
module tb_seq_trigger_detector;

   logic        clk = 1'b0;
   logic        rst;
   logic        arm;
   logic        abort;
   logic [3:0]  in_data;
   logic [15:0] cfg_pattern;
   logic [15:0] cfg_mask;
   logic [1:0]  cfg_last_stage;
   logic [7:0]  cfg_timeout;
   logic [1:0]  state;
   logic [1:0]  stage_idx;
   logic        trig_pulse;
   logic        triggered;
   logic        timeout_pulse;
   logic [3:0]  cap_data;
   logic [7:0]  trig_count;

   int n_checks = 0;
   int n_fails  = 0;
   bit check_en = 1'b0;

   seq_trigger_detector #(
      .WIDTH  (4),
      .STAGES (4),
      .TW     (8),
      .CW     (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .arm            (arm),
      .abort          (abort),
      .in_data        (in_data),
      .cfg_pattern    (cfg_pattern),
      .cfg_mask       (cfg_mask),
      .cfg_last_stage (cfg_last_stage),
      .cfg_timeout    (cfg_timeout),
      .state          (state),
      .stage_idx      (stage_idx),
      .trig_pulse     (trig_pulse),
      .triggered      (triggered),
      .timeout_pulse  (timeout_pulse),
      .cap_data       (cap_data),
      .trig_count     (trig_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: state 0/1/2, stage being searched, cycles waited in that stage.
   int         m_state = 0;
   int         m_stage = 0;
   int         m_wait  = 0;
   int         m_count = 0;
   logic [3:0] m_cap   = '0;
   logic       m_tp    = 1'b0;
   logic       m_to    = 1'b0;
   logic [3:0] m_prev  = '0;

   always @(posedge clk) begin : model
      logic [3:0] mt;
      int         ns, nk, nw, nc, last;
      logic [3:0] ncap;
      logic       ntp, nto;
      for (int k = 0; k < 4; k++)
         mt[k] = ((in_data & cfg_mask[k*4 +: 4]) == (cfg_pattern[k*4 +: 4] & cfg_mask[k*4 +: 4]));
      ns = m_state; nk = m_stage; nw = m_wait; nc = m_count; ncap = m_cap;
      ntp = 1'b0; nto = 1'b0;
      last = (int'(cfg_last_stage) > 3) ? 3 : int'(cfg_last_stage);
      if (rst) begin
         ns = 0; nk = 0; nw = 0; nc = 0; ncap = '0; mt = '0;
      end else if (abort) begin
         ns = 0; nk = 0; nw = 0;
      end else if (arm) begin
         ns = 1; nk = 0; nw = 0;
      end else if (m_state == 1) begin
         if (mt[m_stage] && !m_prev[m_stage]) begin
            if (m_stage == last) begin
               ns = 2; ntp = 1'b1; ncap = in_data;
               nc = (m_count < 255) ? m_count + 1 : 255;
            end else begin
               nk = m_stage + 1; nw = 0;
            end
         end
`ifdef SEQ_TRIGGER_TIMEOUT_EN
         else if (m_stage > 0 && cfg_timeout != 0) begin
            if (m_wait + 1 == int'(cfg_timeout)) begin
               nk = 0; nw = 0; nto = 1'b1;
            end else begin
               nw = m_wait + 1;
            end
         end
`endif
      end
      m_state <= ns; m_stage <= nk; m_wait <= nw; m_count <= nc; m_cap <= ncap;
      m_tp <= ntp; m_to <= nto; m_prev <= mt;
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_state", 32'(state), 32'(m_state));
         chk("cyc_stage_idx", 32'(stage_idx), 32'(m_stage));
         chk("cyc_trig_pulse", 32'(trig_pulse), 32'(m_tp));
         chk("cyc_triggered", 32'(triggered), 32'(m_state == 2));
         chk("cyc_timeout_pulse", 32'(timeout_pulse), 32'(m_to));
         chk("cyc_cap_data", 32'(cap_data), 32'(m_cap));
         chk("cyc_trig_count", 32'(trig_count), 32'(m_count));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] d);
      in_data = d;
      tick();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic set_stage(input int k, input logic [3:0] p, input logic [3:0] m);
      cfg_pattern[k*4 +: 4] = p;
      cfg_mask[k*4 +: 4]    = m;
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; abort = 1'b0; in_data = 4'h0;
      cfg_pattern = 16'hFFFF; cfg_mask = 16'hFFFF;
      cfg_last_stage = 2'd0; cfg_timeout = 8'd0;
      tick();
      check_en = 1'b1;
      tick();
      rst = 1'b0;
      $display("reset: state=%0d stage=%0d count=%0h", state, stage_idx, trig_count);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_stage", 32'(stage_idx), 32'd0);
      chk("reset_count", 32'(trig_count), 32'd0);
      chk("reset_cap", 32'(cap_data), 32'd0);

      // Single stage 0x0 -> 0xA
      set_stage(0, 4'hA, 4'hF);
      pulse_arm();
      chk("single_armed", 32'(state), 32'd1);
      drive(4'hA);
      $display("single stage: trig_pulse=%0d cap=%0h count=%0d", trig_pulse, cap_data, trig_count);
      chk("single_pulse", 32'(trig_pulse), 32'd1);
      chk("single_cap", 32'(cap_data), 32'hA);
      chk("single_count", 32'(trig_count), 32'd1);
      chk("single_state", 32'(state), 32'd2);
      tick();
      chk("single_pulse_end", 32'(trig_pulse), 32'd0);
      chk("single_hold", 32'(triggered), 32'd1);

      // Pattern present before arm must not fire
      pulse_arm();
      drive(4'hA);
      drive(4'hA);
      $display("pre-existing: state=%0d trig_pulse=%0d", state, trig_pulse);
      chk("preexist_no_trig", 32'(state), 32'd1);
      drive(4'h0);
      drive(4'hA);
      chk("preexist_retrig", 32'(trig_pulse), 32'd1);
      chk("preexist_count", 32'(trig_count), 32'd2);

      // Three-stage 0x1 -> 0x3 -> 0x7
      cfg_last_stage = 2'd2;
      set_stage(1, 4'h3, 4'hF);
      set_stage(2, 4'h7, 4'hF);
      set_stage(0, 4'h1, 4'hF);
      in_data = 4'h0;
      pulse_arm();
      drive(4'h1);
      chk("seq3_stage1", 32'(stage_idx), 32'd1);
      drive(4'h3);
      chk("seq3_stage2", 32'(stage_idx), 32'd2);
      drive(4'h7);
      $display("3-stage: trig_pulse=%0d cap=%0h count=%0d", trig_pulse, cap_data, trig_count);
      chk("seq3_trig", 32'(trig_pulse), 32'd1);
      chk("seq3_cap", 32'(cap_data), 32'h7);
      in_data = 4'h0;
      pulse_arm();
      drive(4'h7);
      drive(4'h0);
      chk("seq3_no_advance", 32'(stage_idx), 32'd0);
      chk("seq3_still_wait", 32'(state), 32'd1);

      // Stage timeout
      cfg_timeout = 8'd5;
      drive(4'h1);
      chk("to_advance", 32'(stage_idx), 32'd1);
      for (int i = 0; i < 4; i++) begin
         drive(4'h0);
         chk("to_no_pulse_yet", 32'(timeout_pulse), 32'd0);
      end
      drive(4'h0);
`ifdef SEQ_TRIGGER_TIMEOUT_EN
      $display("timeout: pulse=%0d stage=%0d", timeout_pulse, stage_idx);
      chk("to_pulse", 32'(timeout_pulse), 32'd1);
      chk("to_stage0", 32'(stage_idx), 32'd0);
      drive(4'h1);
      for (int i = 0; i < 4; i++) drive(4'h0);
      drive(4'h3);
      chk("to_edge_wins_stage", 32'(stage_idx), 32'd2);
      chk("to_edge_wins_pulse", 32'(timeout_pulse), 32'd0);
`else
      $display("timeout disabled: pulse=%0d stage=%0d", timeout_pulse, stage_idx);
      chk("to_off_pulse", 32'(timeout_pulse), 32'd0);
      chk("to_off_stage", 32'(stage_idx), 32'd1);
`endif
      cfg_timeout = 8'd0;

      // arm and abort together: abort wins
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("prio_state", 32'(state), 32'd0);
      chk("prio_stage", 32'(stage_idx), 32'd0);
      chk("prio_count_held", 32'(trig_count), 32'd3);

      // Reset in the middle of a sequence
      in_data = 4'h0;
      pulse_arm();
      drive(4'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("mid-wait reset: state=%0d stage=%0d count=%0d", state, stage_idx, trig_count);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_stage", 32'(stage_idx), 32'd0);
      chk("rst_count", 32'(trig_count), 32'd0);
      chk("rst_cap", 32'(cap_data), 32'd0);
      chk("rst_triggered", 32'(triggered), 32'd0);

      // Counter saturation
      cfg_last_stage = 2'd0;
      set_stage(0, 4'hA, 4'hF);
      for (int i = 0; i < 256; i++) begin
         in_data = 4'h0;
         pulse_arm();
         drive(4'hA);
         if (i == 254) chk("sat_255", 32'(trig_count), 32'hFF);
      end
      $display("saturation: count=%0h", trig_count);
      chk("sat_hold", 32'(trig_count), 32'hFF);

      tick();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
